// File: rtl/fibonacci_sequencer_if.sv
// Handshake and data bundle between the Fibonacci sequencer and the
// start button, Fibonacci core, bin2bcd converter and display.
//   start_i/iterations_bcd_i : launch level and 2-digit BCD n
//   fib_*  : core start pulse, n, done pulse and F(n)
//   b2b_*  : converter start pulse, binary in, done pulse, BCD out
//   disp_* : display value and load pulse
//   busy_o/err_o : status
interface fibonacci_sequencer_if #(
    parameter int FIB_W = 20
);
    logic             start_i;
    logic [7:0]       iterations_bcd_i;
    logic             fib_start_o;
    logic [6:0]       fib_n_o;
    logic             fib_done_i;
    logic [FIB_W-1:0] fib_f_i;
    logic             b2b_start_o;
    logic [13:0]      b2b_bin_o;
    logic             b2b_done_i;
    logic [15:0]      b2b_bcd_i;
    logic [15:0]      disp_bcd_o;
    logic             disp_load_o;
    logic             busy_o;
    logic [1:0]       err_o;

    modport master (
        input  start_i, iterations_bcd_i,
        input  fib_done_i, fib_f_i,
        input  b2b_done_i, b2b_bcd_i,
        output fib_start_o, fib_n_o,
        output b2b_start_o, b2b_bin_o,
        output disp_bcd_o, disp_load_o,
        output busy_o, err_o
    );

    modport slave (
        output start_i, iterations_bcd_i,
        output fib_done_i, fib_f_i,
        output b2b_done_i, b2b_bcd_i,
        input  fib_start_o, fib_n_o,
        input  b2b_start_o, b2b_bin_o,
        input  disp_bcd_o, disp_load_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/fibonacci_sequencer.sv
// Fibonacci demo controller: captures a BCD n on a start edge,
// validates it, runs core then bin2bcd, loads the display.
// Ports: clk_i, reset_i (sync, active high), bus (master modport
// of fibonacci_sequencer_if carrying all handshakes and status).
module fibonacci_sequencer #(
    parameter int FIB_W       = 20,
    parameter int MAX_N       = 20,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    fibonacci_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] E_OK   = 2'b00;
    localparam logic [1:0] E_BCD  = 2'b01;
    localparam logic [1:0] E_OVF  = 2'b10;
    localparam logic [1:0] E_TOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FIB,
        S_BCD,
        S_LOAD
    } state_t;

    state_t        state_q;
    logic          start_q;
    logic [7:0]    bcd_q;
    logic [TW-1:0] tmr_q;
    logic          fib_start_q;
    logic [6:0]    fib_n_q;
    logic          b2b_start_q;
    logic [13:0]   b2b_bin_q;
    logic [15:0]   disp_q;
    logic          load_q;
    logic          busy_q;
    logic [1:0]    err_q;

    logic       launch;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       bad_digit;
    logic [6:0] n_bin;

    assign launch    = bus.start_i & ~start_q;
    assign tens      = bcd_q[7:4];
    assign ones      = bcd_q[3:0];
    assign bad_digit = (tens > 4'd9) || (ones > 4'd9);
    // tens*10 = tens*8 + tens*2; max 99 fits in 7 bits
    assign n_bin     = {tens[3:0], 3'b000}
                     + {2'b00, tens, 1'b0}
                     + {3'b000, ones};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            bcd_q       <= '0;
            tmr_q       <= '0;
            fib_start_q <= 1'b0;
            fib_n_q     <= '0;
            b2b_start_q <= 1'b0;
            b2b_bin_q   <= '0;
            disp_q      <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= E_OK;
        end else begin
            start_q     <= bus.start_i;
            fib_start_q <= 1'b0;
            b2b_start_q <= 1'b0;
            load_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        bcd_q   <= bus.iterations_bcd_i;
                        err_q   <= E_OK;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_digit) begin
                        err_q   <= E_BCD;
                        disp_q  <= 16'hEEEE;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else if (n_bin > 7'(MAX_N)) begin
                        err_q   <= E_OVF;
                        disp_q  <= 16'h9999;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        fib_n_q     <= n_bin;
                        fib_start_q <= 1'b1;
                        tmr_q       <= '0;
                        state_q     <= S_FIB;
                    end
                end
                S_FIB: begin
                    if (bus.fib_done_i) begin
                        b2b_bin_q   <= bus.fib_f_i[13:0];
                        b2b_start_q <= 1'b1;
                        tmr_q       <= '0;
                        state_q     <= S_BCD;
                    end else if (tmr_q == T_LAST) begin
                        err_q   <= E_TOUT;
                        disp_q  <= 16'hEEEE;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_BCD: begin
                    if (bus.b2b_done_i) begin
                        disp_q  <= bus.b2b_bcd_i;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else if (tmr_q == T_LAST) begin
                        err_q   <= E_TOUT;
                        disp_q  <= 16'hEEEE;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fib_start_o = fib_start_q;
    assign bus.fib_n_o     = fib_n_q;
    assign bus.b2b_start_o = b2b_start_q;
    assign bus.b2b_bin_o   = b2b_bin_q;
    assign bus.disp_bcd_o  = disp_q;
    assign bus.disp_load_o = load_q;
    assign bus.busy_o      = busy_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench for fibonacci_sequencer with behavioural
// core and bin2bcd responders (3-cycle latency each).
module tb_fibonacci_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fibonacci_sequencer_if #(.FIB_W(20)) bus();

    fibonacci_sequencer #(
        .FIB_W(20),
        .MAX_N(20),
        .TIMEOUT_CYC(1024)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int nvec = 0;
    int nerr = 0;

    int n_fs = 0;
    int n_bs = 0;
    int n_ld = 0;

    bit core_en = 1'b1;
    int inj_req = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int fib_model(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.fib_start_o) n_fs++;
        if (bus.b2b_start_o) n_bs++;
        if (bus.disp_load_o) n_ld++;
    end

    // core / converter responders
    initial begin
        int fcnt = 0;
        int bcnt = 0;
        int fn = 0;
        int bbin = 0;
        int inj_ack = 0;
        bus.fib_done_i = 1'b0;
        bus.fib_f_i    = '0;
        bus.b2b_done_i = 1'b0;
        bus.b2b_bcd_i  = '0;
        forever begin
            @(negedge clk);
            bus.fib_done_i = 1'b0;
            bus.b2b_done_i = 1'b0;
            if (inj_req != inj_ack) begin
                inj_ack = inj_req;
                bus.fib_done_i = 1'b1;
                bus.fib_f_i    = 20'd55;
            end
            if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) begin
                    bus.fib_done_i = 1'b1;
                    bus.fib_f_i    = 20'(fib_model(fn));
                end
            end
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    bus.b2b_done_i = 1'b1;
                    bus.b2b_bcd_i  = to_bcd(bbin);
                end
            end
            if (bus.fib_start_o && core_en) begin
                fn   = int'(bus.fib_n_o);
                fcnt = 3;
            end
            if (bus.b2b_start_o) begin
                bbin = int'(bus.b2b_bin_o);
                bcnt = 3;
            end
        end
    end

    task automatic run(input logic [7:0] bcd,
                       input int hold,
                       input bit bounce,
                       output int lat,
                       output logic busy1);
        int cyc = 0;
        lat   = -1;
        busy1 = 1'b0;
        @(negedge clk);
        bus.iterations_bcd_i = bcd;
        bus.start_i = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = bus.busy_o;
            if (cyc >= hold) bus.start_i = 1'b0;
            if (bounce && cyc >= 2 && cyc <= 6)
                bus.start_i = cyc[0];
            if (bus.disp_load_o) begin
                lat = cyc;
                break;
            end
        end
        bus.start_i = 1'b0;
        if (lat < 0) chk("load_wait", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic b1;
        int fs0, bs0, ld0;
        bus.start_i = 1'b0;
        bus.iterations_bcd_i = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_disp", 32'(bus.disp_bcd_o), 32'd0);
        chk("rst_fs", 32'(bus.fib_start_o), 32'd0);
        chk("rst_fn", 32'(bus.fib_n_o), 32'd0);
        chk("rst_ld", 32'(bus.disp_load_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: n=8 -> 21
        fs0 = n_fs; bs0 = n_bs; ld0 = n_ld;
        run(8'h08, 1, 1'b0, lat, b1);
        chk("t1_busy1", 32'(b1), 32'd1);
        chk("t1_lat", 32'(lat), 32'd10);
        chk("t1_fn", 32'(bus.fib_n_o), 32'd8);
        chk("t1_bin", 32'(bus.b2b_bin_o), 32'd21);
        chk("t1_disp", 32'(bus.disp_bcd_o), 32'h0021);
        chk("t1_err", 32'(bus.err_o), 32'd0);
        chk("t1_nfs", 32'(n_fs - fs0), 32'd1);
        chk("t1_nbs", 32'(n_bs - bs0), 32'd1);
        chk("t1_nld", 32'(n_ld - ld0), 32'd1);
        chk("t1_busy", 32'(bus.busy_o), 32'd0);

        // 2: held start, then bounce while busy
        fs0 = n_fs; ld0 = n_ld;
        run(8'h02, 7, 1'b0, lat, b1);
        repeat (4) @(negedge clk);
        chk("t2_disp", 32'(bus.disp_bcd_o), 32'h0001);
        chk("t2_nfs", 32'(n_fs - fs0), 32'd1);
        chk("t2_nld", 32'(n_ld - ld0), 32'd1);
        fs0 = n_fs;
        run(8'h10, 1, 1'b1, lat, b1);
        repeat (4) @(negedge clk);
        chk("t2b_disp", 32'(bus.disp_bcd_o), 32'h0055);
        chk("t2b_nfs", 32'(n_fs - fs0), 32'd1);

        // 3: boundary n=20 and overflow n=21
        run(8'h20, 1, 1'b0, lat, b1);
        chk("t3_disp", 32'(bus.disp_bcd_o), 32'h6765);
        chk("t3_err", 32'(bus.err_o), 32'd0);
        fs0 = n_fs;
        run(8'h21, 1, 1'b0, lat, b1);
        chk("t3o_lat", 32'(lat), 32'd2);
        chk("t3o_disp", 32'(bus.disp_bcd_o), 32'h9999);
        chk("t3o_err", 32'(bus.err_o), 32'd2);
        chk("t3o_nfs", 32'(n_fs - fs0), 32'd0);
        chk("t3o_busy", 32'(bus.busy_o), 32'd0);

        // 4: bad digit, then n=0
        fs0 = n_fs;
        run(8'h1A, 1, 1'b0, lat, b1);
        chk("t4_lat", 32'(lat), 32'd2);
        chk("t4_err", 32'(bus.err_o), 32'd1);
        chk("t4_disp", 32'(bus.disp_bcd_o), 32'hEEEE);
        chk("t4_nfs", 32'(n_fs - fs0), 32'd0);
        run(8'hA3, 1, 1'b0, lat, b1);
        chk("t4t_err", 32'(bus.err_o), 32'd1);
        run(8'h00, 1, 1'b0, lat, b1);
        chk("t4z_lat", 32'(lat), 32'd10);
        chk("t4z_disp", 32'(bus.disp_bcd_o), 32'h0000);
        chk("t4z_err", 32'(bus.err_o), 32'd0);

        // 5: core never answers
        core_en = 1'b0;
        bs0 = n_bs;
        run(8'h05, 1, 1'b0, lat, b1);
        chk("t5_lat", 32'(lat), 32'd1026);
        chk("t5_err", 32'(bus.err_o), 32'd3);
        chk("t5_disp", 32'(bus.disp_bcd_o), 32'hEEEE);
        inj_req++;
        repeat (5) @(negedge clk);
        chk("t5_nbs", 32'(n_bs - bs0), 32'd0);
        chk("t5_busy", 32'(bus.busy_o), 32'd0);
        chk("t5_errhold", 32'(bus.err_o), 32'd3);
        core_en = 1'b1;

        // 6: reset while waiting on the core
        fs0 = n_fs;
        @(negedge clk);
        bus.iterations_bcd_i = 8'h05;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_nfs", 32'(n_fs - fs0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(bus.busy_o), 32'd0);
        chk("t6_fn", 32'(bus.fib_n_o), 32'd0);
        chk("t6_disp", 32'(bus.disp_bcd_o), 32'd0);
        chk("t6_err", 32'(bus.err_o), 32'd0);
        chk("t6_strobes",
            32'({bus.fib_start_o, bus.b2b_start_o, bus.disp_load_o}),
            32'd0);
        rst = 1'b0;
        fs0 = n_fs; bs0 = n_bs; ld0 = n_ld;
        repeat (6) @(negedge clk);
        chk("t6_late_bs", 32'(n_bs - bs0), 32'd0);
        chk("t6_late_ld", 32'(n_ld - ld0), 32'd0);
        chk("t6_late_bin", 32'(bus.b2b_bin_o), 32'd0);
        run(8'h13, 1, 1'b0, lat, b1);
        chk("t6r_lat", 32'(lat), 32'd10);
        chk("t6r_disp", 32'(bus.disp_bcd_o), 32'h0233);
        chk("t6r_err", 32'(bus.err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
